// File: rtl/cpu_pkg.sv
// Shared RV32 encoding constants: op enumeration, opcode/funct fields, error codes.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned ERR_W = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLL    = 4'd2,
        OP_SLT    = 4'd3,
        OP_SRL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_AND    = 4'd6,
        OP_ADDI   = 4'd7,
        OP_ADDUQB = 4'd8,
        OP_BEQ    = 4'd9,
        OP_LW     = 4'd10,
        OP_SW     = 4'd11,
        OP_LUI    = 4'd12,
        OP_JAL    = 4'd13,
        OP_JALR   = 4'd14,
        OP_AUIPC  = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    localparam logic [OPC_W-1:0] OPC_OP      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;

    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;
    localparam logic [F3_W-1:0] F3_AND     = 3'b111;
    localparam logic [F3_W-1:0] F3_ADDI    = 3'b000;
    localparam logic [F3_W-1:0] F3_LW      = 3'b010;
    localparam logic [F3_W-1:0] F3_SW      = 3'b010;
    localparam logic [F3_W-1:0] F3_BEQ     = 3'b000;
    localparam logic [F3_W-1:0] F3_JALR    = 3'b000;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
    localparam logic [ERR_W-1:0] ERR_UNSUP = 2'b01;
    localparam logic [ERR_W-1:0] ERR_RANGE = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ALIGN = 2'b11;

    localparam logic signed [XLEN-1:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [XLEN-1:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [XLEN-1:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [XLEN-1:0] IMMB_MAX  = 32'sd4094;
    localparam logic signed [XLEN-1:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [XLEN-1:0] IMMJ_MAX  = 32'sd1048574;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } instr_req_t;

    function automatic logic in_range(input logic signed [XLEN-1:0] v,
                                      input logic signed [XLEN-1:0] lo,
                                      input logic signed [XLEN-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic request to RV32 word plus immediate legality.
module instr_pack
    import cpu_pkg::*;
(
    input  instr_req_t       req,
    output logic [XLEN-1:0]  word_c,
    output logic             legal_c,
    output logic [ERR_W-1:0] err_code_c
);

    logic [OPC_W-1:0]        opc;
    logic [F3_W-1:0]         f3;
    logic [F7_W-1:0]         f7;
    fmt_e                    fmt;
    logic                    supported;
    logic signed [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]         imm;

    assign imm   = req.imm;
    assign imm_s = $signed(req.imm);

    // Field lookup per operation.
    always_comb begin
        opc       = '0;
        f3        = '0;
        f7        = F7_BASE;
        fmt       = FMT_R;
        supported = 1'b1;
        case (req.op)
            OP_ADD:    begin opc = OPC_OP;      f3 = F3_ADD_SUB; end
            OP_SUB:    begin opc = OPC_OP;      f3 = F3_ADD_SUB; f7 = F7_ALT; end
            OP_SLL:    begin opc = OPC_OP;      f3 = F3_SLL;     end
            OP_SLT:    begin opc = OPC_OP;      f3 = F3_SLT;     end
            OP_SRL:    begin opc = OPC_OP;      f3 = F3_SRL_SRA; end
            OP_SRA:    begin opc = OPC_OP;      f3 = F3_SRL_SRA; f7 = F7_ALT; end
            OP_AND:    begin opc = OPC_OP;      f3 = F3_AND;     end
            OP_ADDUQB: begin opc = OPC_CUSTOM0; f3 = F3_ADD_SUB; end
            OP_ADDI:   begin opc = OPC_OP_IMM;  f3 = F3_ADDI; fmt = FMT_I; end
            OP_LW:     begin opc = OPC_LOAD;    f3 = F3_LW;   fmt = FMT_I; end
            OP_JALR:   begin opc = OPC_JALR;    f3 = F3_JALR; fmt = FMT_I; end
            OP_SW:     begin opc = OPC_STORE;   f3 = F3_SW;   fmt = FMT_S; end
            OP_BEQ:    begin opc = OPC_BRANCH;  f3 = F3_BEQ;  fmt = FMT_B; end
            OP_LUI:    begin opc = OPC_LUI;     fmt = FMT_U; end
            OP_AUIPC:  begin opc = OPC_AUIPC;   fmt = FMT_U; end
            OP_JAL:    begin opc = OPC_JAL;     fmt = FMT_J; end
            default:   supported = 1'b0;
        endcase
    end

    // Immediate checks; range failure outranks misalignment.
    always_comb begin
        err_code_c = ERR_NONE;
        case (fmt)
            FMT_I, FMT_S: begin
                if (!in_range(imm_s, IMM12_MIN, IMM12_MAX)) err_code_c = ERR_RANGE;
            end
            FMT_B: begin
                if (!in_range(imm_s, IMMB_MIN, IMMB_MAX)) err_code_c = ERR_RANGE;
                else if (imm[0])                            err_code_c = ERR_ALIGN;
            end
            FMT_J: begin
                if (!in_range(imm_s, IMMJ_MIN, IMMJ_MAX)) err_code_c = ERR_RANGE;
                else if (imm[0])                            err_code_c = ERR_ALIGN;
            end
            FMT_U: begin
                if (imm[11:0] != 12'd0) err_code_c = ERR_ALIGN;
            end
            default: err_code_c = ERR_NONE;
        endcase
        if (!supported) err_code_c = ERR_UNSUP;
        legal_c = (err_code_c == ERR_NONE);
    end

    // Bit placement per format.
    always_comb begin
        word_c = '0;
        case (fmt)
            FMT_R: word_c = {f7, req.rs2, req.rs1, f3, req.rd, opc};
            FMT_I: word_c = {imm[11:0], req.rs1, f3, req.rd, opc};
            FMT_S: word_c = {imm[11:5], req.rs2, req.rs1, f3, imm[4:0], opc};
            FMT_B: word_c = {imm[12], imm[10:5], req.rs2, req.rs1, f3, imm[4:1], imm[11], opc};
            FMT_U: word_c = {imm[31:12], req.rd, opc};
            FMT_J: word_c = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, opc};
            default: word_c = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32 instruction encoder: handshake, output register, address counter, count, errors.
module instr_encoder
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    input  logic [XLEN-1:0]    imm,
    input  logic               addr_load,
    input  logic [ADDR_W-1:0]  addr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err,
    output logic [ERR_W-1:0]   err_code,
    output logic [CNT_W-1:0]   count
);

    instr_req_t        req;
    logic [XLEN-1:0]   word_c;
    logic              legal_c;
    logic [ERR_W-1:0]  code_c;
    logic              accept_c;
    logic              fire_c;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] word_addr_c;

    assign req = '{op: op_e'(op), rd: rd, rs1: rs1, rs2: rs2, imm: imm};

    instr_pack u_pack (
        .req        (req),
        .word_c     (word_c),
        .legal_c    (legal_c),
        .err_code_c (code_c)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;
    assign fire_c   = out_valid && out_ready;

    // next_addr is the address the next accepted word will take; a load redirects it.
    assign word_addr_c = addr_load ? addr_in : next_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
        end else begin
            if (accept_c && legal_c) begin
                out_valid <= 1'b1;
                out_instr <= word_c;
                out_addr  <= word_addr_c;
                next_addr <= word_addr_c + ADDR_W'(4);
            end else begin
                if (fire_c)    out_valid <= 1'b0;
                if (addr_load) next_addr <= addr_in;
            end

            if (fire_c) count <= count + CNT_W'(1);

            err <= accept_c && !legal_c;
            if (accept_c && !legal_c) err_code <= code_c;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized checks of instr_encoder against a table-driven reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] count;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference tables indexed by op number.
    int unsigned opc_t [16] = '{'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h13,
                                'h0B, 'h63, 'h03, 'h23, 'h37, 'h6F, 'h67, 'h17};
    int unsigned f3_t  [16] = '{0, 0, 1, 2, 5, 5, 7, 0, 0, 0, 2, 2, 0, 0, 0, 0};
    int unsigned f7_t  [16] = '{0, 'h20, 0, 0, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    string       fmt_s      = "RRRRRRRIRBISUJIU";
    int          bnd   [14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                                -4097, 1048574, 1048575, 1048576, -1048576, -1048577};

    bit          mv;
    logic [31:0] mi, ma, mnext;
    int unsigned mcnt;
    bit          merr;
    logic [1:0]  mcode;

    function automatic void ref_encode(input int o, input int unsigned d, input int unsigned s1,
                                       input int unsigned s2, input int iv,
                                       output logic [31:0] w, output logic [1:0] code);
        int unsigned u = iv;
        int unsigned base;
        byte f = fmt_s[o];
        code = 2'd0;
        case (f)
            "I", "S": if (iv < -2048 || iv > 2047) code = 2'd2;
            "B": if (iv < -4096 || iv > 4094) code = 2'd2;
                 else if ((iv & 1) != 0) code = 2'd3;
            "J": if (iv < -(1 << 20) || iv > (1 << 20) - 2) code = 2'd2;
                 else if ((iv & 1) != 0) code = 2'd3;
            "U": if ((u & 'hFFF) != 0) code = 2'd3;
            default: code = 2'd0;
        endcase
        base = (s1 << 15) | (f3_t[o] << 12) | opc_t[o];
        case (f)
            "R": w = 32'(base | (f7_t[o] << 25) | (s2 << 20) | (d << 7));
            "I": w = 32'(base | ((u & 'hFFF) << 20) | (d << 7));
            "S": w = 32'(base | (((u >> 5) & 'h7F) << 25) | (s2 << 20) | ((u & 'h1F) << 7));
            "B": w = 32'(base | (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (s2 << 20)
                         | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7));
            "U": w = 32'((u & 'hFFFFF000) | (d << 7) | opc_t[o]);
            default: w = 32'((((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21)
                             | (((u >> 11) & 1) << 20) | (((u >> 12) & 'hFF) << 12)
                             | (d << 7) | opc_t[o]);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input int o, input int d, input int s1, input int s2, input int iv);
        in_valid = 1'b1;
        op  = 4'(o);
        rd  = 5'(d);
        rs1 = 5'(s1);
        rs2 = 5'(s2);
        imm = 32'(iv);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: check in_ready, advance the model, then compare all registered outputs.
    task automatic tick();
        logic [31:0] w;
        logic [1:0]  c;
        bit rdy, acc, fire;
        #1;
        rdy = !mv || out_ready;
        if (!reset) chk("in_ready", 32'(in_ready), 32'(rdy));
        ref_encode(int'(op), rd, rs1, rs2, int'(imm), w, c);
        acc  = in_valid && rdy;
        fire = mv && out_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            mv = 0; mi = '0; ma = '0; mnext = '0; mcnt = 0; merr = 0; mcode = '0;
        end else begin
            if (acc && c == 2'd0) begin
                ma    = addr_load ? addr_in : mnext;
                mi    = w;
                mv    = 1;
                mnext = ma + 32'd4;
            end else begin
                if (fire) mv = 0;
                if (addr_load) mnext = addr_in;
            end
            if (fire) mcnt = (mcnt + 1) & 'hFFFF;
            merr = acc && c != 2'd0;
            if (merr) mcode = c;
        end
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("out_instr", out_instr, mi);
        chk("out_addr",  out_addr,  ma);
        chk("err",       32'(err),  32'(merr));
        chk("err_code",  32'(err_code), 32'(mcode));
        chk("count",     32'(count), mcnt);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        addr_load = 1'b0; addr_in = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr",  out_addr, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b0;

        req(0, 3, 1, 2, 0); tick();
        chk("add_word", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, 32'h0);
        idle(); tick();
        chk("add_count", 32'(count), 32'd1);

        reset = 1'b1; tick(); reset = 1'b0;
        req(7, 5, 0, 0, -1); tick();
        chk("addi_word", out_instr, 32'hFFF00293);
        chk("addi_addr", out_addr, 32'h0);
        req(12, 2, 0, 0, 'h12345000); tick();
        chk("lui_word", out_instr, 32'h12345137);
        chk("lui_addr", out_addr, 32'h4);
        chk("lui_valid", 32'(out_valid), 32'd1);
        req(9, 0, 1, 2, 8); tick();
        chk("beq_word", out_instr, 32'h00208463);
        req(13, 1, 0, 0, 2048); tick();
        chk("jal_word", out_instr, 32'h001000EF);

        req(7, 5, 0, 0, 2048); tick();
        chk("range_err", 32'(err), 32'd1);
        chk("range_code", 32'(err_code), 32'd2);
        chk("range_valid", 32'(out_valid), 32'd0);
        idle(); tick();
        chk("err_pulse", 32'(err), 32'd0);
        req(9, 0, 1, 2, 7); tick();
        chk("align_code", 32'(err_code), 32'd3);
        idle(); tick();

        out_ready = 1'b0;
        req(0, 3, 1, 2, 0); tick();
        chk("stall_addr0", out_addr, 32'h10);
        req(7, 1, 1, 0, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_word", out_instr, 32'h002081B3);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        idle(); out_ready = 1'b1; addr_load = 1'b1; addr_in = 32'h100; tick();
        addr_load = 1'b0;
        req(0, 3, 1, 2, 0); tick();
        chk("load_addr", out_addr, 32'h100);

        out_ready = 1'b0;
        req(1, 4, 5, 6, 0); tick();
        reset = 1'b1; idle(); tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_addr",  out_addr, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        reset = 1'b0; out_ready = 1'b1;

        for (int n = 0; n < 600; n++) begin
            int iv;
            case ($urandom_range(0, 5))
                0: iv = int'($urandom_range(0, 64)) - 32;
                1: iv = bnd[$urandom_range(0, 13)];
                2: iv = (int'($urandom_range(0, 'h3FFF)) - 'h2000) & ~1;
                3: iv = int'($urandom);
                4: iv = int'($urandom & 32'hFFFFF000);
                default: iv = int'($urandom_range(0, 'h3FFFFF)) - 'h200000;
            endcase
            req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), iv);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_load = !in_valid && ($urandom_range(0, 7) == 0);
            addr_in   = $urandom & 32'hFFFFFFFC;
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; addr_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
